// File: rtl/multi_cam_compositor.sv
// Multi-camera compositor: pass-through of one camera stream, or side-by-side tiling of all streams
// through per-channel FIFOs and a round-robin arbiter. Define COMPOSITOR_OVF_EN for sticky overflow flags.
module multi_cam_compositor #(
  parameter int NUM_CAM        = 2,
  parameter int CAM_DATA_WIDTH = 12,
  parameter int CAM_LINE       = 9,
  parameter int CAM_PIXEL      = 10,
  parameter int TILE_WIDTH     = 160,
  parameter int TILE_DEPTH     = 240,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_CAM-1:0]                  i_we,
  input  logic [NUM_CAM*CAM_DATA_WIDTH-1:0]   i_data,
  input  logic [NUM_CAM*CAM_LINE-1:0]         i_line,
  input  logic [NUM_CAM*CAM_PIXEL-1:0]        i_pixel,
  input  logic [NUM_CAM*CAM_LINE-1:0]         i_imag_depth,
  input  logic [NUM_CAM*CAM_PIXEL-1:0]        i_imag_width,
  input  logic                                i_mode,
  input  logic [$clog2(NUM_CAM)-1:0]          i_sel,
  input  logic                                i_ovf_clr,
  output logic                                o_we,
  output logic [CAM_DATA_WIDTH-1:0]           o_data_wr,
  output logic [CAM_LINE-1:0]                 o_line,
  output logic [CAM_PIXEL-1:0]                o_pixel,
  output logic [CAM_LINE-1:0]                 o_imag_depth,
  output logic [CAM_PIXEL-1:0]                o_imag_width,
  output logic [NUM_CAM-1:0]                  o_ovf
);

  localparam int SW = $clog2(NUM_CAM);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {MODE_PASS = 1'b0, MODE_COMP = 1'b1} mode_t;

  typedef struct packed {
    logic [CAM_LINE-1:0]       line;
    logic [CAM_PIXEL-1:0]      pixel;
    logic [CAM_DATA_WIDTH-1:0] data;
  } entry_t;

  logic [CAM_DATA_WIDTH-1:0] data_a  [NUM_CAM];
  logic [CAM_LINE-1:0]       line_a  [NUM_CAM];
  logic [CAM_PIXEL-1:0]      pixel_a [NUM_CAM];
  logic [CAM_LINE-1:0]       depth_a [NUM_CAM];
  logic [CAM_PIXEL-1:0]      width_a [NUM_CAM];
  entry_t                    entry_in[NUM_CAM];

  entry_t          mem    [NUM_CAM][FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr [NUM_CAM];
  logic [AW-1:0]   rd_ptr [NUM_CAM];
  logic [AW:0]     cnt    [NUM_CAM];

  logic [NUM_CAM-1:0] push, pop, full, ovf_set;

  mode_t         mode_q, mode_p;
  logic [SW-1:0] sel_q, sel_p;
  logic          flush;
  logic [SW-1:0] arb_ptr;
  logic [SW-1:0] gnt;
  logic          gnt_vld;
  entry_t        head;

  // Per-channel unpacking, tile mapping (channel 0 is the rightmost tile) and FIFO handshake terms
  for (genvar k = 0; k < NUM_CAM; k++) begin : g_ch
    logic [CAM_PIXEL-1:0] pix_clip;
    assign data_a[k]  = i_data[k*CAM_DATA_WIDTH +: CAM_DATA_WIDTH];
    assign line_a[k]  = i_line[k*CAM_LINE +: CAM_LINE];
    assign pixel_a[k] = i_pixel[k*CAM_PIXEL +: CAM_PIXEL];
    assign depth_a[k] = i_imag_depth[k*CAM_LINE +: CAM_LINE];
    assign width_a[k] = i_imag_width[k*CAM_PIXEL +: CAM_PIXEL];
    assign pix_clip   = (pixel_a[k] > CAM_PIXEL'(TILE_WIDTH-1)) ? CAM_PIXEL'(TILE_WIDTH-1) : pixel_a[k];
    assign entry_in[k] = '{line:  line_a[k],
                           pixel: pix_clip + CAM_PIXEL'((NUM_CAM-1-k)*TILE_WIDTH),
                           data:  data_a[k]};
    assign full[k]    = (cnt[k] == (AW+1)'(FIFO_DEPTH));
    assign pop[k]     = (mode_q == MODE_COMP) && !flush && gnt_vld && (gnt == SW'(k));
    assign push[k]    = (mode_q == MODE_COMP) && !flush && i_we[k] && (!full[k] || pop[k]);
    assign ovf_set[k] = (mode_q == MODE_COMP) && !flush && i_we[k] && full[k] && !pop[k];
  end

  assign flush = (mode_q != mode_p) || (sel_q != sel_p);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_PASS;
      mode_p <= MODE_PASS;
      sel_q  <= '0;
      sel_p  <= '0;
    end else begin
      mode_q <= mode_t'(i_mode);
      sel_q  <= i_sel;
      mode_p <= mode_q;
      sel_p  <= sel_q;
    end
  end

  // Round-robin search starting at arb_ptr, which holds the channel after the last grant
  always_comb begin
    int unsigned   idx;
    logic [SW-1:0] cand;
    gnt_vld = 1'b0;
    gnt     = '0;
    idx     = 0;
    cand    = '0;
    for (int unsigned off = 0; off < NUM_CAM; off++) begin
      idx  = (int'(arb_ptr) + off) % NUM_CAM;
      cand = SW'(idx);
      if (!gnt_vld && (cnt[cand] != '0)) begin
        gnt_vld = 1'b1;
        gnt     = cand;
      end
    end
  end

  assign head = mem[gnt][rd_ptr[gnt]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      arb_ptr <= '0;
    else if (flush)
      arb_ptr <= '0;
    else if (pop != '0)
      arb_ptr <= (gnt == SW'(NUM_CAM-1)) ? '0 : gnt + SW'(1);
  end

  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < NUM_CAM; k++)
      if (push[k]) mem[k][wr_ptr[k]] <= entry_in[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NUM_CAM; k++) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
        cnt[k]    <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < NUM_CAM; k++) begin
        if (flush) begin
          wr_ptr[k] <= '0;
          rd_ptr[k] <= '0;
          cnt[k]    <= '0;
        end else begin
          if (push[k]) wr_ptr[k] <= wr_ptr[k] + AW'(1);
          if (pop[k])  rd_ptr[k] <= rd_ptr[k] + AW'(1);
          if (push[k] && !pop[k])
            cnt[k] <= cnt[k] + (AW+1)'(1);
          else if (pop[k] && !push[k])
            cnt[k] <= cnt[k] - (AW+1)'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_we         <= 1'b0;
      o_data_wr    <= '0;
      o_line       <= '0;
      o_pixel      <= '0;
      o_imag_depth <= '0;
      o_imag_width <= '0;
    end else if (mode_q == MODE_PASS) begin
      o_we         <= i_we[sel_q];
      o_data_wr    <= data_a[sel_q];
      o_line       <= line_a[sel_q];
      o_pixel      <= pixel_a[sel_q];
      o_imag_depth <= depth_a[sel_q];
      o_imag_width <= width_a[sel_q];
    end else begin
      o_imag_depth <= CAM_LINE'(TILE_DEPTH);
      o_imag_width <= CAM_PIXEL'(NUM_CAM*TILE_WIDTH);
      if (pop != '0) begin
        o_we      <= 1'b1;
        o_line    <= head.line;
        o_pixel   <= head.pixel;
        o_data_wr <= head.data;
      end else begin
        o_we      <= 1'b0;
      end
    end
  end

`ifdef COMPOSITOR_OVF_EN
  // A new overflow in the same cycle as a clear wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      o_ovf <= '0;
    else
      o_ovf <= (i_ovf_clr ? '0 : o_ovf) | ovf_set;
  end
`else
  logic unused_ovf;
  assign unused_ovf = ^{i_ovf_clr, ovf_set};
  assign o_ovf      = '0;
`endif

endmodule
